// File: rtl/uart_rom_loader_if.sv
// Byte-stream input and memory-write output bundle of the UART ROM loader.
// The master side feeds received bytes in; the slave side is the loader itself.
interface uart_rom_loader_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        mem_we_o;
  logic [11:0] mem_addr_o;
  logic [7:0]  mem_data_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output rx_data_i, rx_valid_i,
    input  mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o, err_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i,
    output mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/uart_rom_loader.sv
// UART ROM loader: parses MAGIC, LEN_HI, LEN_LO, payload, CSUM from the rx byte
// stream and writes the payload into CHIP-8 memory starting at LOAD_BASE.
// busy_o keeps the CHIP-8 core in reset while a frame is being received.
module uart_rom_loader #(
  parameter logic [7:0]  MAGIC       = 8'hA5,
  parameter logic [11:0] LOAD_BASE   = 12'h200,
  parameter int          MAX_LEN     = 3584,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  uart_rom_loader_if.slave    bus
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] remaining_q, remaining_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        mem_we_q, mem_we_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_data_q, mem_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [15:0] len_w;
  logic        active;
  logic        fin_ok;
  logic        fin_bad;

  assign len_w  = {len_hi_q, bus.rx_data_i};
  assign active = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                  (state_q == S_DATA)   || (state_q == S_CSUM);

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    addr_d      = addr_q;
    sum_d       = sum_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    fin_ok      = 1'b0;
    fin_bad     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid_i && (bus.rx_data_i == MAGIC)) begin
          state_d  = S_LEN_HI;
          busy_d   = 1'b1;
          len_hi_d = 8'h00;
          timer_d  = '0;
        end
      end
      S_LEN_HI: begin
        if (bus.rx_valid_i) begin
          len_hi_d = bus.rx_data_i;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (bus.rx_valid_i) begin
          // A bounded, non-zero length guarantees the last write lands at or below 0xFFF.
          if ((len_w == 16'd0) || (len_w > 16'(MAX_LEN))) begin
            fin_bad = 1'b1;
          end else begin
            state_d     = S_DATA;
            addr_d      = LOAD_BASE;
            sum_d       = 8'h00;
            remaining_d = len_w;
          end
        end
      end
      S_DATA: begin
        if (bus.rx_valid_i) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_data_d  = bus.rx_data_i;
          addr_d      = addr_q + 12'd1;
          sum_d       = sum_q + bus.rx_data_i;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        // The checksum byte is compared only, never written to memory.
        if (bus.rx_valid_i) begin
          if (bus.rx_data_i == sum_q) begin
            fin_ok = 1'b1;
          end else begin
            fin_bad = 1'b1;
          end
        end
      end
      S_DONE: begin
        // Any byte arriving in this cycle is dropped, not MAGIC-checked.
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Inter-byte watchdog; a byte arriving on the expiry cycle wins over the timeout.
    if (active) begin
      if (bus.rx_valid_i) begin
        timer_d = '0;
      end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
        fin_bad = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    if (fin_ok) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      timer_d = '0;
    end else if (fin_bad) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      timer_d = '0;
    end
  end

  // State and registered outputs; async reset abandons any frame silently.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      len_hi_q    <= 8'h00;
      addr_q      <= 12'h000;
      sum_q       <= 8'h00;
      remaining_q <= 16'h0000;
      timer_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 12'h000;
      mem_data_q  <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      addr_q      <= addr_d;
      sum_q       <= sum_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_we_o   = mem_we_q;
  assign bus.mem_addr_o = mem_addr_q;
  assign bus.mem_data_o = mem_data_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Testbench for uart_rom_loader: scoreboard of expected memory writes plus
// per-scenario tasks checking done/err pulses, busy and timing.
module tb_uart_rom_loader;

  localparam int TIMEOUT = 16;

  logic clk;
  logic rstn;

  uart_rom_loader_if bif();

  uart_rom_loader #(
    .MAGIC       (8'hA5),
    .LOAD_BASE   (12'h200),
    .MAX_LEN     (3584),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int wr_cnt = 0;

  logic [19:0] exp_q[$];

  // Monitor: pops expected {addr,data} for every write and counts pulses.
  always @(negedge clk) begin
    logic [19:0] e;
    if (rstn) begin
      if (bif.done_o) done_cnt++;
      if (bif.err_o) err_cnt++;
      if (bif.mem_we_o) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", bif.mem_addr_o, bif.mem_data_o);
        end else begin
          e = exp_q.pop_front();
          if ({bif.mem_addr_o, bif.mem_data_o} !== e) begin
            errors++;
            $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h", bif.mem_addr_o, bif.mem_data_o, e[19:8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic push_wr(input logic [11:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bif.rx_data_i  = b;
    bif.rx_valid_i = 1'b1;
    @(negedge clk);
    bif.rx_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    int d0, e0;
    // Outputs under power-on reset
    checks++;
    if ({bif.mem_we_o, bif.mem_addr_o, bif.mem_data_o, bif.busy_o, bif.done_o, bif.err_o} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 000000", {bif.mem_we_o, bif.mem_addr_o, bif.mem_data_o, bif.busy_o, bif.done_o, bif.err_o});
    end
    idle(2);
    rstn = 1'b1;
    idle(2);
    // Reset in the middle of DATA
    d0 = done_cnt; e0 = err_cnt;
    push_wr(12'h200, 8'h11);
    push_wr(12'h201, 8'h22);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h11); send_byte(8'h22);
    checks++;
    if (bif.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_frame: got %b, expected 1", bif.busy_o);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({bif.mem_we_o, bif.mem_addr_o, bif.mem_data_o, bif.busy_o, bif.done_o, bif.err_o} !== 24'h0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h, expected 000000", {bif.mem_we_o, bif.mem_addr_o, bif.mem_data_o, bif.busy_o, bif.done_o, bif.err_o});
    end
    idle(2);
    rstn = 1'b1;
    idle(20);
    checks++;
    if ((done_cnt - d0) != 0 || (err_cnt - e0) != 0) begin
      errors++;
      $display("FAIL reset_no_pulse: got done=%0d err=%0d, expected 0 0", done_cnt - d0, err_cnt - e0);
    end
    // Clean restart after reset
    push_wr(12'h200, 8'h7E);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h7E); send_byte(8'h7E);
    idle(3);
    checks++;
    if ((done_cnt - d0) != 1 || (err_cnt - e0) != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_restart: got done=%0d err=%0d pending=%0d, expected 1 0 0", done_cnt - d0, err_cnt - e0, exp_q.size());
    end
  endtask

  task automatic test_good_frame;
    int d0, e0, w0;
    d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
    push_wr(12'h200, 8'h11);
    push_wr(12'h201, 8'h22);
    push_wr(12'h202, 8'h33);
    send_byte(8'hA5);
    checks++;
    if (bif.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL good_busy_after_magic: got %b, expected 1", bif.busy_o);
    end
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h66);
    checks++;
    if (bif.done_o !== 1'b1 || bif.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL good_done_latency: got done=%b busy=%b, expected 1 0", bif.done_o, bif.busy_o);
    end
    idle(3);
    checks++;
    if ((done_cnt - d0) != 1 || (err_cnt - e0) != 0 || (wr_cnt - w0) != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL good_frame: got done=%0d err=%0d writes=%0d, expected 1 0 3", done_cnt - d0, err_cnt - e0, wr_cnt - w0);
    end
  endtask

  task automatic test_bad_csum;
    int d0, e0, w0;
    d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
    push_wr(12'h200, 8'h01);
    push_wr(12'h201, 8'h02);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04);
    idle(3);
    checks++;
    if ((done_cnt - d0) != 0 || (err_cnt - e0) != 1 || (wr_cnt - w0) != 2) begin
      errors++;
      $display("FAIL bad_csum: got done=%0d err=%0d writes=%0d, expected 0 1 2", done_cnt - d0, err_cnt - e0, wr_cnt - w0);
    end
  endtask

  task automatic test_bad_len;
    int e0, w0;
    e0 = err_cnt; w0 = wr_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if (bif.err_o !== 1'b1) begin
      errors++;
      $display("FAIL len_zero_err: got %b, expected 1", bif.err_o);
    end
    idle(2);
    send_byte(8'hA5); send_byte(8'h0E); send_byte(8'h01);
    checks++;
    if (bif.err_o !== 1'b1) begin
      errors++;
      $display("FAIL len_over_err: got %b, expected 1", bif.err_o);
    end
    idle(3);
    checks++;
    if ((err_cnt - e0) != 2 || (wr_cnt - w0) != 0) begin
      errors++;
      $display("FAIL bad_len: got err=%0d writes=%0d, expected 2 0", err_cnt - e0, wr_cnt - w0);
    end
  endtask

  task automatic test_max_frame;
    int d0, e0, w0;
    logic [7:0] sum;
    logic [7:0] b;
    d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
    sum = 8'h00;
    send_byte(8'hA5); send_byte(8'h0E); send_byte(8'h00);
    for (int i = 0; i < 3584; i++) begin
      b = 8'(i * 7 + 3);
      sum = sum + b;
      push_wr(12'(12'h200 + i), b);
      send_byte(b);
    end
    send_byte(sum);
    idle(3);
    checks++;
    if ((done_cnt - d0) != 1 || (err_cnt - e0) != 0 || (wr_cnt - w0) != 3584 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL max_frame: got done=%0d err=%0d writes=%0d, expected 1 0 3584", done_cnt - d0, err_cnt - e0, wr_cnt - w0);
    end
    checks++;
    if (bif.mem_addr_o !== 12'hFFF) begin
      errors++;
      $display("FAIL max_last_addr: got %h, expected fff", bif.mem_addr_o);
    end
  endtask

  task automatic test_timeout;
    int d0, e0, n;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h00); send_byte(8'hFF);
    checks++;
    if (bif.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL junk_ignored: got busy=%b, expected 0", bif.busy_o);
    end
    push_wr(12'h200, 8'h01);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04); send_byte(8'h01);
    n = 0;
    while (bif.err_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles, expected %0d", n, TIMEOUT);
    end
    idle(3);
    checks++;
    if ((err_cnt - e0) != 1 || (done_cnt - d0) != 0 || exp_q.size() != 0 || bif.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout: got err=%0d done=%0d pending=%0d busy=%b, expected 1 0 0 0", err_cnt - e0, done_cnt - d0, exp_q.size(), bif.busy_o);
    end
  endtask

  task automatic test_back_to_back;
    int d0, e0;
    logic [7:0] seq [11];
    d0 = done_cnt; e0 = err_cnt;
    seq = '{8'hA5, 8'h00, 8'h01, 8'h55, 8'h55, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'hAA, 8'hAA};
    push_wr(12'h200, 8'h55);
    push_wr(12'h200, 8'hAA);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bif.rx_data_i  = seq[i];
      bif.rx_valid_i = 1'b1;
    end
    @(negedge clk);
    bif.rx_valid_i = 1'b0;
    idle(3);
    checks++;
    if ((done_cnt - d0) != 2 || (err_cnt - e0) != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: got done=%0d err=%0d pending=%0d, expected 2 0 0", done_cnt - d0, err_cnt - e0, exp_q.size());
    end
  endtask

  initial begin
    rstn = 1'b0;
    bif.rx_data_i  = 8'h00;
    bif.rx_valid_i = 1'b0;
    #1;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_max_frame();
    test_timeout();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
